// File: rtl/ethernet_pkg.sv
// Shared constants and helpers for the ethernet frame packer.
// Holds the legal lanes-per-word range and the keep-field width function.
package ethernet_pkg;

    localparam int RATIO_MIN = 2;
    localparam int RATIO_MAX = 8;

    // Width needed to count 0..ratio valid lanes.
    function automatic int keep_w(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/ethernet_word_reg.sv
// Output holding register with a valid/ready handshake.
// Ports: load/data/keep/last/partial in; out_* word and out_valid out; out_ready in.
module ethernet_word_reg
    import ethernet_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int KW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [OUT_W-1:0] data,
    input  logic [KW-1:0]    keep,
    input  logic             last,
    input  logic             partial,
    output logic [OUT_W-1:0] out_data,
    output logic [KW-1:0]    out_keep,
    output logic             out_last,
    output logic             out_partial,
    output logic             out_valid,
    input  logic             out_ready
);

    // The producer only asserts load when the slot is empty or draining,
    // so loading always wins over the handshake clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data    <= '0;
            out_keep    <= '0;
            out_last    <= 1'b0;
            out_partial <= 1'b0;
            out_valid   <= 1'b0;
        end else if (load) begin
            out_data    <= data;
            out_keep    <= keep;
            out_last    <= last;
            out_partial <= partial;
            out_valid   <= 1'b1;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/ethernet_frame_packer.sv
// Packs IN_W-bit lanes into RATIO-lane words, first lane in the LSBs.
// Ports: clk, reset, in_* lane stream with in_ready; out_* word stream with out_ready.
module ethernet_frame_packer
    import ethernet_pkg::*;
#(
    parameter  int IN_W  = 4,
    parameter  int RATIO = 2,
    localparam int OUT_W = IN_W * RATIO,
    localparam int KW    = keep_w(RATIO)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             in_abort,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [KW-1:0]    out_keep,
    output logic             out_last,
    output logic             out_partial,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [KW-1:0]    lane_cnt;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] lane_word;
    logic [OUT_W-1:0] word;
    logic             full_lane;
    logic             completing;
    logic             take;
    logic             load;

    assign full_lane  = (lane_cnt == KW'(RATIO - 1));
    assign completing = in_last || full_lane;

    // A lane that only fills the accumulator never needs the output slot,
    // so it may be taken even while the pending word is stalled.
    assign in_ready = !reset && (!out_valid || out_ready || !completing);
    assign take     = in_valid && in_ready && !in_abort;
    assign load     = take && completing;

    // Lanes above lane_cnt are still zero in acc, which zero-fills short words.
    assign lane_word = OUT_W'(in_data) << (lane_cnt * IN_W);
    assign word      = acc | lane_word;

    always_ff @(posedge clk) begin
        if (reset || in_abort) begin
            lane_cnt <= '0;
            acc      <= '0;
        end else if (take) begin
            if (completing) begin
                lane_cnt <= '0;
                acc      <= '0;
            end else begin
                lane_cnt <= lane_cnt + 1'b1;
                acc      <= word;
            end
        end
    end

    ethernet_word_reg #(
        .OUT_W(OUT_W),
        .KW   (KW)
    ) u_word_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data       (word),
        .keep       (lane_cnt + 1'b1),
        .last       (in_last),
        .partial    (in_last && !full_lane),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_partial(out_partial),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

endmodule

// File: tb/tb_ethernet_frame_packer.sv
// Self-checking bench: vector table on RATIO=2, hand sequences on RATIO=4.
// Drives inputs 1ns after the rising edge and samples 1ns after the next one.
module tb_ethernet_frame_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] in_data;
    logic       in_valid, in_last, in_abort, in_ready, out_ready;
    logic [7:0] out_data;
    logic [1:0] out_keep;
    logic       out_last, out_partial, out_valid;

    logic [3:0]  q_data;
    logic        q_valid, q_last, q_abort, q_ready, q_oready;
    logic [15:0] q_odata;
    logic [2:0]  q_okeep;
    logic        q_olast, q_opartial, q_ovalid;

    int total = 0;
    int bad   = 0;

    ethernet_frame_packer dut2 (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_abort(in_abort), .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_partial(out_partial), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    ethernet_frame_packer #(.IN_W(4), .RATIO(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_data(q_data), .in_valid(q_valid), .in_last(q_last),
        .in_abort(q_abort), .in_ready(q_ready),
        .out_data(q_odata), .out_keep(q_okeep), .out_last(q_olast),
        .out_partial(q_opartial), .out_valid(q_ovalid),
        .out_ready(q_oready)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [3:0] d;
        logic       l;
        logic       ab;
        logic       rdy;
        logic       e_irdy;
        logic       e_ov;
        logic [7:0] e_data;
        logic [1:0] e_keep;
        logic       e_last;
        logic       e_part;
        logic       full;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, v, input logic [3:0] d,
                                input logic l, ab, rdy, e_irdy, e_ov,
                                input logic [7:0] e_data,
                                input logic [1:0] e_keep,
                                input logic e_last, e_part, full);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.l = l; r.ab = ab; r.rdy = rdy;
        r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_data = e_data;
        r.e_keep = e_keep; r.e_last = e_last; r.e_part = e_part;
        r.full = full;
        return r;
    endfunction

    initial begin
        reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        in_abort = 1'b0; out_ready = 1'b0;
        q_data = '0; q_valid = 1'b0; q_last = 1'b0; q_abort = 1'b0;
        q_oready = 1'b1;

        //        rst v d    l ab rdy irdy ov data  kp la pa full
        tv.push_back(mk(1,0,4'h0,0,0,0, 0,0,8'h00,0,0,0,1));
        // two lanes, last on second
        tv.push_back(mk(0,1,4'h5,0,0,1, 1,0,8'h00,0,0,0,1));
        tv.push_back(mk(0,1,4'hA,1,0,1, 1,1,8'hA5,2,1,0,0));
        // three lanes: full word then partial, back to back
        tv.push_back(mk(0,1,4'h1,0,0,1, 1,0,8'h00,0,0,0,0));
        tv.push_back(mk(0,1,4'h2,0,0,1, 1,1,8'h21,2,0,0,0));
        tv.push_back(mk(0,1,4'h3,1,0,1, 1,1,8'h03,1,1,1,0));
        tv.push_back(mk(0,0,4'h0,0,0,1, 1,0,8'h00,0,0,0,0));
        // backpressure with C3 pending
        tv.push_back(mk(0,1,4'h3,0,0,1, 1,0,8'h00,0,0,0,0));
        tv.push_back(mk(0,1,4'hC,0,0,0, 1,1,8'hC3,2,0,0,0));
        tv.push_back(mk(0,1,4'hD,0,0,0, 1,1,8'hC3,2,0,0,0));
        tv.push_back(mk(0,1,4'hE,0,0,0, 0,1,8'hC3,2,0,0,0));
        tv.push_back(mk(0,1,4'hE,0,0,0, 0,1,8'hC3,2,0,0,0));
        tv.push_back(mk(0,1,4'hE,0,0,0, 0,1,8'hC3,2,0,0,0));
        tv.push_back(mk(0,1,4'hE,0,0,0, 0,1,8'hC3,2,0,0,0));
        tv.push_back(mk(0,1,4'hE,1,0,1, 1,1,8'hED,2,1,0,0));
        tv.push_back(mk(0,0,4'h0,0,0,1, 1,0,8'h00,0,0,0,0));
        // abort discards the 7
        tv.push_back(mk(0,1,4'h7,0,0,1, 1,0,8'h00,0,0,0,0));
        tv.push_back(mk(0,1,4'hF,0,1,1, 1,0,8'h00,0,0,0,0));
        tv.push_back(mk(0,1,4'h4,0,0,1, 1,0,8'h00,0,0,0,0));
        tv.push_back(mk(0,1,4'h8,1,0,1, 1,1,8'h84,2,1,0,0));
        // reset mid-frame with a pending word
        tv.push_back(mk(0,0,4'h0,0,0,0, 1,1,8'h84,2,1,0,0));
        tv.push_back(mk(0,1,4'h9,0,0,0, 1,1,8'h84,2,1,0,0));
        tv.push_back(mk(1,1,4'h6,0,0,0, 0,0,8'h00,0,0,0,1));
        tv.push_back(mk(0,1,4'h9,0,0,1, 1,0,8'h00,0,0,0,1));
        tv.push_back(mk(0,1,4'h6,1,0,1, 1,1,8'h69,2,1,0,0));
        tv.push_back(mk(0,0,4'h0,0,0,1, 1,0,8'h00,0,0,0,0));

        @(posedge clk); #1;
        foreach (tv[i]) begin
            reset     = tv[i].rst;
            in_valid  = tv[i].v;
            in_data   = tv[i].d;
            in_last   = tv[i].l;
            in_abort  = tv[i].ab;
            out_ready = tv[i].rdy;
            #1;
            chk("in_ready", i, 32'(in_ready), 32'(tv[i].e_irdy));
            @(posedge clk); #1;
            chk("out_valid", i, 32'(out_valid), 32'(tv[i].e_ov));
            if (tv[i].e_ov || tv[i].full) begin
                chk("out_data", i, 32'(out_data), 32'(tv[i].e_data));
                chk("out_keep", i, 32'(out_keep), 32'(tv[i].e_keep));
                chk("out_last", i, 32'(out_last), 32'(tv[i].e_last));
                chk("out_partial", i, 32'(out_partial), 32'(tv[i].e_part));
            end
        end
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_abort = 1'b0;

        // RATIO=4: eight continuous lanes, two full words, no stall
        for (int k = 1; k <= 8; k++) begin
            q_valid = 1'b1;
            q_data  = 4'(k);
            q_last  = (k == 8);
            #1;
            chk("r4_in_ready", k, 32'(q_ready), 32'd1);
            @(posedge clk); #1;
            chk("r4_valid", k, 32'(q_ovalid), 32'((k == 4) || (k == 8)));
            if (k == 4) begin
                chk("r4_data", k, 32'(q_odata), 32'h4321);
                chk("r4_keep", k, 32'(q_okeep), 32'd4);
                chk("r4_last", k, 32'(q_olast), 32'd0);
            end
            if (k == 8) begin
                chk("r4_data", k, 32'(q_odata), 32'h8765);
                chk("r4_keep", k, 32'(q_okeep), 32'd4);
                chk("r4_last", k, 32'(q_olast), 32'd1);
                chk("r4_partial", k, 32'(q_opartial), 32'd0);
            end
        end

        // RATIO=4: three-lane frame gives a zero-filled partial word
        for (int k = 1; k <= 3; k++) begin
            q_valid = 1'b1;
            q_data  = 4'(k);
            q_last  = (k == 3);
            @(posedge clk); #1;
        end
        q_valid = 1'b0; q_last = 1'b0;
        chk("r4p_valid", 0, 32'(q_ovalid), 32'd1);
        chk("r4p_data", 0, 32'(q_odata), 32'h0321);
        chk("r4p_keep", 0, 32'(q_okeep), 32'd3);
        chk("r4p_last", 0, 32'(q_olast), 32'd1);
        chk("r4p_partial", 0, 32'(q_opartial), 32'd1);
        @(posedge clk); #1;
        chk("r4p_drain", 0, 32'(q_ovalid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ethernet_frame_packer.md
ETHERNET_FRAME_PACKER -- requirements
Module: ethernet_frame_packer

Interface
REQ-001 SHALL have parameter IN_W, default 4, input lane width in bits (MII nibble).
REQ-002 SHALL have parameter RATIO, default 2, input lanes per output word, legal range 2..8.
REQ-003 SHALL derive OUT_W = IN_W*RATIO and KW = clog2(RATIO+1).
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  IN_W  input lane.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_last  input  1  lane is final lane of frame.
REQ-009 SHALL have port in_abort  input  1  discard current partial word.
REQ-010 SHALL have port in_ready  output  1  lane accepted this cycle when high with in_valid.
REQ-011 SHALL have port out_data  output  OUT_W  packed word.
REQ-012 SHALL have port out_keep  output  KW  count of valid lanes in out_data.
REQ-013 SHALL have port out_last  output  1  word ends a frame.
REQ-014 SHALL have port out_partial  output  1  frame ended with out_keep < RATIO.
REQ-015 SHALL have port out_valid  output  1  output word valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts word.

Function
REQ-017 SHALL accept a lane when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-018 SHALL place the k-th accepted lane of a word at out_data[k*IN_W +: IN_W], first lane in LSBs.
REQ-019 SHALL track fill with lane counter lane_cnt, range 0..RATIO-1, reset 0.
REQ-020 SHALL, on accepted lane with lane_cnt==RATIO-1 and in_last=0, load output register next edge: out_keep=RATIO, out_last=0, out_partial=0, out_valid=1, lane_cnt=0.
REQ-021 SHALL, on accepted lane with in_last=1, load output register next edge: out_keep=lane_cnt+1, out_last=1, out_partial=(lane_cnt!=RATIO-1), out_valid=1, lane_cnt=0.
REQ-022 SHALL drive unfilled lanes of a partial word to zero.
REQ-023 SHALL have latency of exactly 1 cycle from accepting the completing lane to out_valid high.
REQ-024 SHALL hold out_data/out_keep/out_last/out_partial/out_valid stable while out_valid && !out_ready.
REQ-025 SHALL clear out_valid after out_valid && out_ready unless a new word is loaded the same edge (back-to-back, no bubble).
REQ-026 SHALL, on in_abort high, clear lane_cnt and accumulator next edge, ignore any lane offered that cycle, and leave a pending output word untouched.
REQ-027 SHALL accept lanes into the accumulator while out_valid && !out_ready only if lane_cnt<RATIO-1 and in_last=0; completing lanes stall (in_ready refinement overrides REQ-017).
REQ-028 SHALL treat in_valid=0 cycles as idle: no state change except output handshake.

Reset
REQ-029 SHALL, on reset, set lane_cnt=0, accumulator=0, out_data=0, out_keep=0, out_last=0, out_partial=0, out_valid=0 at next edge.
REQ-030 SHALL discard any partial word and pending output when reset asserts mid-frame; in_ready SHALL be 0 while reset is high.

Structure
REQ-031 SHALL place RATIO limits and a keep-width function in shared package ethernet_pkg.
REQ-032 SHALL use one sub-module ethernet_word_reg (output holding register with valid/ready); accumulator and lane counter in top.

Verification
REQ-033 Default params, lanes 0x5,0xA, in_last on 2nd, out_ready=1 -> next cycle out_data=0xA5, keep=2, last=1, partial=0.
REQ-034 Lanes 0x1,0x2,0x3 with in_last on 3rd -> words 0x21 (keep 2, last 0) then 0x03 (keep 1, last 1, partial 1).
REQ-035 out_ready=0 for 5 cycles with word 0xC3 pending, stream continues -> word held stable, 1 lane absorbed, completing lane stalled (in_ready=0), no loss after release.
REQ-036 Lane 0x7 accepted then in_abort -> no output; following lanes 0x4,0x8 give 0x84 keep 2.
REQ-037 RATIO=4, lanes 0x1..0x8 continuous with out_ready=1 -> words 0x4321, 0x8765 on consecutive-valid cycles, no bubble.
REQ-038 Reset asserted after one lane of a frame -> all outputs 0 next edge; next frame 0x9,0x6 packs to 0x69.
